// File: rtl/i2c_slave_responder_pkg.sv
// rtl/i2c_slave_responder_pkg.sv - shared types and constants for the I2C slave responder
//
// Package i2c_slv_pkg
//   state_t          : protocol FSM states
//   ACK / NACK       : SDA levels for the acknowledge slot (also the output-enable value)
//   DEFAULT_SLV_ADDR : 7-bit address answered when not overridden
//   addr_match()     : compares a received address byte against a 7-bit address

package i2c_slv_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_WAIT_STOP
  } state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam logic [6:0] DEFAULT_SLV_ADDR = 7'h50;

  // Address byte carries the R/W flag in bit 0.
  function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] addr);
    return addr_byte[7:1] == addr;
  endfunction

endpackage

// File: rtl/i2c_slave_responder_if.sv
// rtl/i2c_slave_responder_if.sv - pad and write-strobe bundle of the I2C slave responder
//
// Parameter AW : width of WR_ADDR_O (log2 of register-file depth)
// Signals
//   SCL_PAD_I, SDA_PAD_I       : resolved bus levels
//   SCL_PAD_O, SCL_PADOEN_O    : SCL pad driver (never enabled)
//   SDA_PAD_O, SDA_PADOEN_O    : SDA open-drain driver, OEN=0 pulls low
//   BUSY_O                     : transaction in progress
//   WR_STB_O, WR_ADDR_O, WR_DATA_O : one-cycle notification of each stored byte
// Modports: slave (the responder), master (bus/host side)

interface i2c_slave_responder_if #(
  parameter int AW = 4
);

  logic          SCL_PAD_I;
  logic          SDA_PAD_I;
  logic          SCL_PAD_O;
  logic          SCL_PADOEN_O;
  logic          SDA_PAD_O;
  logic          SDA_PADOEN_O;
  logic          BUSY_O;
  logic          WR_STB_O;
  logic [AW-1:0] WR_ADDR_O;
  logic [7:0]    WR_DATA_O;

  modport slave (
    input  SCL_PAD_I, SDA_PAD_I,
    output SCL_PAD_O, SCL_PADOEN_O, SDA_PAD_O, SDA_PADOEN_O,
    output BUSY_O, WR_STB_O, WR_ADDR_O, WR_DATA_O
  );

  modport master (
    output SCL_PAD_I, SDA_PAD_I,
    input  SCL_PAD_O, SCL_PADOEN_O, SDA_PAD_O, SDA_PADOEN_O,
    input  BUSY_O, WR_STB_O, WR_ADDR_O, WR_DATA_O
  );

endinterface

// File: rtl/i2c_slave_responder_sync_edge.sv
// rtl/i2c_slave_responder_sync_edge.sv - two-flop synchronizer with edge detect for one bus line
//
// Ports
//   clk, rst_n : system clock, asynchronous active-low reset
//   line_in    : asynchronous bus level
//   level      : synchronized level
//   rise, fall : one-cycle pulses on synchronized transitions

module i2c_slv_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic hist;

  // Reset to 1 so an idle (pulled-up) bus produces no edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      sync <= 1'b1;
      hist <= 1'b1;
    end else begin
      meta <= line_in;
      sync <= meta;
      hist <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~hist;
  assign fall  = ~sync & hist;

endmodule

// File: rtl/i2c_slave_responder.sv
// rtl/i2c_slave_responder.sv - I2C slave with pointer-addressed 8-bit register file
//
// Parameters
//   SLV_ADDR  : 7-bit bus address answered
//   MEM_DEPTH : number of 8-bit registers (power of two)
// Ports
//   WB_CLK_I  : system clock (rising edge)
//   ARST_I    : asynchronous active-low reset
//   bus       : pad / status / write-strobe bundle (slave modport)

module i2c_slave_responder
  import i2c_slv_pkg::*;
#(
  parameter logic [6:0] SLV_ADDR  = DEFAULT_SLV_ADDR,
  parameter int         MEM_DEPTH = 16
) (
  input  logic                  WB_CLK_I,
  input  logic                  ARST_I,
  i2c_slave_responder_if.slave  bus
);

  localparam int AW = $clog2(MEM_DEPTH);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_slv_sync_edge u_scl_sync (
    .clk     (WB_CLK_I),
    .rst_n   (ARST_I),
    .line_in (bus.SCL_PAD_I),
    .level   (scl_lvl),
    .rise    (scl_rise),
    .fall    (scl_fall)
  );

  i2c_slv_sync_edge u_sda_sync (
    .clk     (WB_CLK_I),
    .rst_n   (ARST_I),
    .line_in (bus.SDA_PAD_I),
    .level   (sda_lvl),
    .rise    (sda_rise),
    .fall    (sda_fall)
  );

  state_t        state;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [AW-1:0] ptr;
  logic          rw;
  logic          ack_bit;
  logic          sda_oen;
  logic          busy;
  logic          wr_stb;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;

  logic [7:0]    mem [MEM_DEPTH];
  logic [7:0]    mem_rd;
  logic [7:0]    mem_nxt;
  logic [7:0]    next_byte;
  logic          start_det;
  logic          stop_det;

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;
  assign next_byte = {shreg[6:0], sda_lvl};
  assign mem_rd    = mem[ptr];
  assign mem_nxt   = mem[ptr + AW'(1)];

  // Register file has no reset; it is written one cycle after the strobe is raised.
  always_ff @(posedge WB_CLK_I) begin
    if (wr_stb) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Acknowledge slots use bit_cnt as a phase marker: 8 means the slot has not
  // opened yet (waiting for the SCL fall after the 8th bit), 0 means SDA is
  // being held for the 9th clock and the next fall closes the slot.
  always_ff @(posedge WB_CLK_I or negedge ARST_I) begin
    if (!ARST_I) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      ptr     <= '0;
      rw      <= 1'b0;
      ack_bit <= NACK;
      sda_oen <= 1'b1;
      busy    <= 1'b0;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_stb <= 1'b0;
      // Bus conditions take priority over any SCL edge in the same cycle.
      if (start_det) begin
        state   <= ST_ADDR;
        bit_cnt <= '0;
        busy    <= 1'b1;
        sda_oen <= 1'b1;
      end else if (stop_det) begin
        state   <= ST_IDLE;
        bit_cnt <= '0;
        busy    <= 1'b0;
        sda_oen <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            sda_oen <= 1'b1;
          end

          ST_ADDR: begin
            if (scl_rise) begin
              shreg   <= next_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                if (addr_match(next_byte, SLV_ADDR)) begin
                  state <= ST_ADDR_ACK;
                  rw    <= sda_lvl;
                end else begin
                  state <= ST_WAIT_STOP;
                  busy  <= 1'b0;
                end
              end
            end
          end

          ST_ADDR_ACK: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oen <= ACK;
                bit_cnt <= '0;
              end else if (rw) begin
                state   <= ST_RD_BYTE;
                shreg   <= mem_rd;
                sda_oen <= mem_rd[7];
              end else begin
                state   <= ST_PTR;
                sda_oen <= 1'b1;
              end
            end
          end

          ST_PTR: begin
            if (scl_rise) begin
              shreg   <= next_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                ptr   <= next_byte[AW-1:0];
                state <= ST_PTR_ACK;
              end
            end
          end

          ST_WR_BYTE: begin
            if (scl_rise) begin
              shreg   <= next_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                wr_stb  <= 1'b1;
                wr_addr <= ptr;
                wr_data <= next_byte;
                ptr     <= ptr + AW'(1);
                state   <= ST_WR_ACK;
              end
            end
          end

          ST_PTR_ACK, ST_WR_ACK: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oen <= ACK;
                bit_cnt <= '0;
              end else begin
                sda_oen <= 1'b1;
                state   <= ST_WR_BYTE;
              end
            end
          end

          ST_RD_BYTE: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oen <= 1'b1;
                bit_cnt <= '0;
                state   <= ST_RD_ACK;
              end else begin
                // shreg[7] is on the bus; present the next bit.
                shreg   <= {shreg[6:0], 1'b0};
                sda_oen <= shreg[6];
              end
            end
          end

          ST_RD_ACK: begin
            if (scl_rise) begin
              ack_bit <= sda_lvl;
              bit_cnt <= 4'd1;
            end else if (scl_fall && bit_cnt == 4'd1) begin
              bit_cnt <= '0;
              if (ack_bit == ACK) begin
                ptr     <= ptr + AW'(1);
                shreg   <= mem_nxt;
                sda_oen <= mem_nxt[7];
                state   <= ST_RD_BYTE;
              end else begin
                sda_oen <= 1'b1;
                state   <= ST_WAIT_STOP;
              end
            end
          end

          ST_WAIT_STOP: begin
            sda_oen <= 1'b1;
          end

          default: begin
            state   <= ST_IDLE;
            sda_oen <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.SCL_PAD_O    = 1'b0;
  assign bus.SCL_PADOEN_O = 1'b1;
  assign bus.SDA_PAD_O    = 1'b0;
  assign bus.SDA_PADOEN_O = sda_oen;
  assign bus.BUSY_O       = busy;
  assign bus.WR_STB_O     = wr_stb;
  assign bus.WR_ADDR_O    = wr_addr;
  assign bus.WR_DATA_O    = wr_data;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// tb/tb_i2c_slave_responder.sv - scoreboard bench for the I2C slave responder

module tb_i2c_slave_responder;

  localparam int Q = 200;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  wire  sda_bus;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt  = 0;
  int oen_low_cnt = 0;

  logic [15:0] exp_rx [$];
  logic [15:0] obs_rx [$];
  logic [11:0] exp_wr [$];

  always #5 clk = ~clk;

  i2c_slave_responder_if #(.AW(4)) bif ();

  assign sda_bus       = sda_m & (bif.SDA_PADOEN_O | bif.SDA_PAD_O);
  assign bif.SDA_PAD_I = sda_bus;
  assign bif.SCL_PAD_I = scl_m & (bif.SCL_PADOEN_O | bif.SCL_PAD_O);

  i2c_slave_responder #(.SLV_ADDR(7'h50), .MEM_DEPTH(16)) dut (
    .WB_CLK_I (clk),
    .ARST_I   (rst_n),
    .bus      (bif)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes a write or the
  // master records a received ACK/data byte.
  initial begin
    forever begin
      @(negedge clk);
      if (bif.WR_STB_O === 1'b1) begin
        wr_cnt++;
        if (exp_wr.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL wr_unexpected: got 0x%0h required no strobe", {bif.WR_ADDR_O, bif.WR_DATA_O});
        end else begin
          check("wr_strobe", {20'd0, bif.WR_ADDR_O, bif.WR_DATA_O}, {20'd0, exp_wr.pop_front()});
        end
      end
      if (obs_rx.size() > 0) begin
        if (exp_rx.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rx_unexpected: got 0x%0h required nothing", obs_rx.pop_front());
        end else begin
          check("rx", {16'd0, obs_rx.pop_front()}, {16'd0, exp_rx.pop_front()});
        end
      end
      if (rst_n && bif.SDA_PADOEN_O === 1'b0) oen_low_cnt++;
    end
  end

  task automatic bit_io(input logic b, output logic r);
    sda_m = b;
    #Q scl_m = 1'b1;
    #Q r = sda_bus;
    #Q scl_m = 1'b0;
    #Q;
  endtask

  task automatic start_c();
    sda_m = 1'b1;
    #Q scl_m = 1'b1;
    #Q sda_m = 1'b0;
    #Q scl_m = 1'b0;
    #Q;
  endtask

  task automatic stop_c();
    sda_m = 1'b0;
    #Q scl_m = 1'b1;
    #Q sda_m = 1'b1;
    #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack);
    logic r;
    exp_rx.push_back({8'hAC, 7'd0, exp_ack});
    for (int i = 7; i >= 0; i--) bit_io(b[i], r);
    bit_io(1'b1, r);
    obs_rx.push_back({8'hAC, 7'd0, r});
  endtask

  task automatic read_byte(input logic [7:0] expv, input logic mack);
    logic r;
    logic [7:0] d;
    exp_rx.push_back({8'hDA, expv});
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, r);
      d[i] = r;
    end
    bit_io(mack, r);
    obs_rx.push_back({8'hDA, d});
  endtask

  initial begin
    int w0;
    int c0;
    logic r;
    logic [3:0] nib;

    repeat (5) @(posedge clk);
    #1;
    check("rst_sda_oen", bif.SDA_PADOEN_O, 1);
    check("rst_busy", bif.BUSY_O, 0);
    check("rst_wr_stb", bif.WR_STB_O, 0);
    check("rst_wr_addr", bif.WR_ADDR_O, 0);
    check("rst_wr_data", bif.WR_DATA_O, 0);
    check("scl_padoen", bif.SCL_PADOEN_O, 1);
    check("scl_pad_o", bif.SCL_PAD_O, 0);
    check("sda_pad_o", bif.SDA_PAD_O, 0);
    rst_n = 1'b1;
    #Q;

    // Plain write of two data bytes at pointer 3.
    w0 = wr_cnt;
    exp_wr.push_back({4'h3, 8'h11});
    exp_wr.push_back({4'h4, 8'h22});
    start_c();
    check("busy_after_start", bif.BUSY_O, 1);
    send_byte(8'hA0, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    stop_c();
    #Q;
    check("busy_after_stop", bif.BUSY_O, 0);
    check("write_strobe_count", wr_cnt - w0, 2);

    // Set pointer, repeated START, read back with ACK then NACK.
    start_c();
    send_byte(8'hA0, 1'b0);
    send_byte(8'h03, 1'b0);
    start_c();
    send_byte(8'hA1, 1'b0);
    read_byte(8'h11, 1'b0);
    read_byte(8'h22, 1'b1);
    check("sda_released_after_nack", bif.SDA_PADOEN_O, 1);
    check("busy_until_stop", bif.BUSY_O, 1);
    stop_c();
    #Q;
    check("busy_after_read_stop", bif.BUSY_O, 0);

    // Foreign address: no ACK and no SDA activity until the next START.
    c0 = oen_low_cnt;
    start_c();
    send_byte(8'hA4, 1'b1);
    check("busy_after_addr_nack", bif.BUSY_O, 0);
    send_byte(8'h55, 1'b1);
    check("no_sda_activity", oen_low_cnt - c0, 0);
    stop_c();
    #Q;

    // Pointer wrap on write and on read.
    exp_wr.push_back({4'hF, 8'hAA});
    exp_wr.push_back({4'h0, 8'hBB});
    start_c();
    send_byte(8'hA0, 1'b0);
    send_byte(8'h0F, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    stop_c();
    #Q;
    start_c();
    send_byte(8'hA0, 1'b0);
    send_byte(8'h0F, 1'b0);
    start_c();
    send_byte(8'hA1, 1'b0);
    read_byte(8'hAA, 1'b0);
    read_byte(8'hBB, 1'b1);
    stop_c();
    #Q;

    // Reset during the 5th data bit of a read of 0x11 (that bit is 0).
    start_c();
    send_byte(8'hA0, 1'b0);
    send_byte(8'h03, 1'b0);
    start_c();
    send_byte(8'hA1, 1'b0);
    for (int i = 3; i >= 0; i--) begin
      bit_io(1'b1, r);
      nib[i] = r;
    end
    check("read_first_nibble", nib, 4'h1);
    sda_m = 1'b1;
    #Q scl_m = 1'b1;
    #Q;
    check("read_bit5_driven_low", bif.SDA_PADOEN_O, 0);
    rst_n = 1'b0;
    #1;
    check("reset_releases_sda", bif.SDA_PADOEN_O, 1);
    check("reset_clears_busy", bif.BUSY_O, 0);
    #Q rst_n = 1'b1;
    #Q;
    exp_wr.push_back({4'h5, 8'h5A});
    start_c();
    send_byte(8'hA0, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h5A, 1'b0);
    stop_c();
    #Q;

    // STOP in the middle of a data byte.
    w0 = wr_cnt;
    start_c();
    send_byte(8'hA0, 1'b0);
    send_byte(8'h07, 1'b0);
    bit_io(1'b1, r);
    bit_io(1'b0, r);
    bit_io(1'b1, r);
    stop_c();
    #Q;
    check("busy_after_mid_stop", bif.BUSY_O, 0);
    check("no_strobe_mid_stop", wr_cnt - w0, 0);

    repeat (20) @(posedge clk);
    #1;
    check("wr_queue_drained", exp_wr.size(), 0);
    check("rx_queue_drained", exp_rx.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_slave_responder.md
I2C_SLAVE_RESPONDER -- requirements
Module: i2c_slave_responder

Interface
REQ-001 SHALL have parameter SLV_ADDR, default 7'h50, the 7-bit address the block answers to.
REQ-002 SHALL have parameter MEM_DEPTH, default 16, the number of 8-bit register-file entries (power of two).
REQ-003 SHALL have port WB_CLK_I  input  1  the single system clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port ARST_I  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port SCL_PAD_I  input  1  resolved bus SCL level.
REQ-006 SHALL have port SDA_PAD_I  input  1  resolved bus SDA level.
REQ-007 SHALL have port SCL_PAD_O  output  1  tied 0 (no clock stretching).
REQ-008 SHALL have port SCL_PADOEN_O  output  1  tied 1, so SCL is never driven.
REQ-009 SHALL have port SDA_PAD_O  output  1  tied 0 (open-drain pull-down only).
REQ-010 SHALL have port SDA_PADOEN_O  output  1  0 pulls SDA low; 1 releases it.
REQ-011 SHALL have port BUSY_O  output  1  high from START until STOP or address NACK.
REQ-012 SHALL have port WR_STB_O  output  1  one-cycle pulse per byte stored to memory.
REQ-013 SHALL have port WR_ADDR_O  output  log2(MEM_DEPTH)  memory index of the stored byte; WR_DATA_O  output  8  the stored byte.

Function
REQ-014 SHALL pass SCL and SDA through 2-flop synchronizers, then one history flop for edge detection; all decisions use the synchronized values.
REQ-015 SHALL detect START (incl. repeated START) as synced SDA falling while synced SCL is high, from any state -> ADDR, bit counter cleared.
REQ-016 SHALL detect STOP as synced SDA rising while synced SCL is high, from any state -> IDLE, SDA released.
REQ-017 SHALL sample SDA on synced SCL rising edge, MSB first; SHALL change SDA_PADOEN_O only in the cycle after a synced SCL falling edge.
REQ-018 SHALL implement states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP.
REQ-019 ADDR: after 8 bits, if bits[7:1]==SLV_ADDR -> ADDR_ACK (SDA low for the 9th clock), else -> WAIT_STOP with SDA released.
REQ-020 ADDR_ACK: on the 9th SCL falling edge, R/W=0 -> PTR; R/W=1 -> RD_BYTE, driving bit 7 of mem[ptr].
REQ-021 PTR: the first write byte loads ptr = byte mod MEM_DEPTH, is ACKed (PTR_ACK), and is not stored -> WR_BYTE.
REQ-022 WR_BYTE/WR_ACK: each byte is ACKed, written to mem[ptr], and WR_STB_O pulses in the cycle the 8th bit is sampled; ptr then increments.
REQ-023 RD_BYTE drives mem[ptr] MSB first (SDA released for 1, pulled for 0); RD_ACK samples the master bit on the 9th SCL rise.
REQ-024 RD_ACK: master ACK (0) -> ptr increments, next byte -> RD_BYTE; master NACK (1) -> WAIT_STOP, SDA released.
REQ-025 ptr SHALL wrap from MEM_DEPTH-1 to 0 on both read and write, with no error.
REQ-026 ptr SHALL persist across transactions, so a repeated START plus a read continues from the pointer set by the write.
REQ-027 When START/STOP and an SCL edge fall in the same cycle, START/STOP SHALL win.
REQ-028 SDA_PADOEN_O SHALL be 1 in IDLE and WAIT_STOP, and whenever the block is not ACKing or driving read data.

Reset
REQ-029 While ARST_I is low: state=IDLE, ptr=0, synchronizers=1, SDA_PADOEN_O=1, BUSY_O=0, WR_STB_O=0, WR_ADDR_O=0, WR_DATA_O=0; memory contents undefined.
REQ-030 Reset asserted mid-transfer SHALL release SDA asynchronously; after deassertion the block SHALL ignore the bus until the next START.

Structure
REQ-031 Package i2c_slv_pkg SHALL hold the state enum, the ACK/NACK constants and the default address.
REQ-032 Sub-module i2c_slv_sync_edge SHALL implement the synchronizer plus rise/fall detect for one line, instantiated twice.

Verification
REQ-033 Write 0xA0, 0x03, 0x11, 0x22 then STOP -> ACK on all four bytes, mem[3]=0x11, mem[4]=0x22, two WR_STB_O pulses.
REQ-034 Write 0xA0, 0x03; repeated START; 0xA1; read two bytes with ACK then NACK -> returns 0x11, 0x22; SDA released after the NACK.
REQ-035 Address 0xA4 -> no ACK, BUSY_O low, no SDA activity until the next START.
REQ-036 Write ptr 0x0F, then data 0xAA, 0xBB -> mem[15]=0xAA, mem[0]=0xBB (wrap).
REQ-037 Assert ARST_I during the 5th data bit of a read -> SDA_PADOEN_O=1 immediately; the next full write transaction completes correctly.
REQ-038 STOP inserted mid-byte -> IDLE, no WR_STB_O pulse, BUSY_O low.
